// File: rtl/cntry_vehicle_detector_if.sv
// Bus between the country-road detector and its surroundings.
//   master : sensor/controller side; drives arrive_raw, depart_raw, cntry
//            and observes X, queue_cnt, overflow, timeout.
//   slave  : the detector itself.
// Ports carried:
//   arrive_raw / depart_raw : raw asynchronous loop-sensor levels
//   cntry                   : country light (0 RED, 1 YELLOW, 2 GREEN, 3 RED)
//   X                       : car-present request to the controller
//   queue_cnt               : queued car count
//   overflow                : sticky lost-arrival flag
//   timeout                 : one-cycle pulse on max-green expiry
interface cntry_vehicle_detector_if #(
  parameter int CNT_W = 4
);
  logic             arrive_raw;
  logic             depart_raw;
  logic [1:0]       cntry;
  logic             X;
  logic [CNT_W-1:0] queue_cnt;
  logic             overflow;
  logic             timeout;

  modport master (
    output arrive_raw, depart_raw, cntry,
    input  X, queue_cnt, overflow, timeout
  );

  modport slave (
    input  arrive_raw, depart_raw, cntry,
    output X, queue_cnt, overflow, timeout
  );
endinterface

// File: rtl/cntry_vehicle_detector.sv
// Country-road vehicle detector: conditions two loop sensors (2-flop sync +
// debounce + rising-edge event), keeps a saturating queue of waiting cars and
// raises the request X toward the traffic controller. X is dropped when the
// queue drains or after MAX_GREEN cycles of green so the highway is never
// starved.
// Ports:
//   clock : system clock, posedge
//   clear : synchronous active-low reset
//   bus   : slave side of cntry_vehicle_detector_if (sensors, light, X,
//           queue_cnt, overflow, timeout)
module cntry_vehicle_detector #(
  parameter int DEBOUNCE  = 3,
  parameter int CNT_W     = 4,
  parameter int MAX_GREEN = 8
) (
  input  logic                     clock,
  input  logic                     clear,
  cntry_vehicle_detector_if.slave  bus
);

  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int TW = $clog2(MAX_GREEN + 1);

  // Channel 0 = arrival sensor, channel 1 = departure sensor.
  logic [1:0]    s1, s2, filt, filt_d;
  logic [DW-1:0] dcnt [2];
  logic [1:0]    rise;

  always_ff @(posedge clock) begin
    if (!clear) begin
      s1     <= '0;
      s2     <= '0;
      filt   <= '0;
      filt_d <= '0;
      for (int i = 0; i < 2; i++) dcnt[i] <= '0;
    end else begin
      s1     <= {bus.depart_raw, bus.arrive_raw};
      s2     <= s1;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        // Count consecutive samples that disagree with the filtered level;
        // the DEBOUNCE-th one flips the level and restarts the count.
        if (s2[i] == filt[i])
          dcnt[i] <= '0;
        else if (dcnt[i] == DW'(DEBOUNCE - 1)) begin
          filt[i] <= s2[i];
          dcnt[i] <= '0;
        end else
          dcnt[i] <= dcnt[i] + 1'b1;
      end
    end
  end

  assign rise = filt & ~filt_d;

  // ---------------- queue ----------------
  logic [CNT_W-1:0] qcnt;
  logic             ovf;
  logic             arr_ev, dep_ok, light_go;

  assign arr_ev   = rise[0];
  assign light_go = (bus.cntry == 2'd1) || (bus.cntry == 2'd2);
  // A departure only counts while the light lets cars through and there is
  // someone to leave; otherwise it is noise from the sensor.
  assign dep_ok   = rise[1] && light_go && (qcnt != '0);

  always_ff @(posedge clock) begin
    if (!clear) begin
      qcnt <= '0;
      ovf  <= 1'b0;
    end else if (arr_ev && !dep_ok) begin
      if (qcnt == '1) ovf  <= 1'b1;
      else            qcnt <= qcnt + 1'b1;
    end else if (dep_ok && !arr_ev) begin
      qcnt <= qcnt - 1'b1;
    end
  end

  // ---------------- request FSM ----------------
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVE   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic          to_q, to_n;
  logic          x_q, x_n;
  logic          light_red;

  assign light_red = (bus.cntry == 2'd0) || (bus.cntry == 2'd3);

  always_ff @(posedge clock) begin
    if (!clear) begin
      state <= S_IDLE;
      timer <= '0;
      to_q  <= 1'b0;
      x_q   <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      to_q  <= to_n;
      x_q   <= x_n;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    to_n    = 1'b0;
    case (state)
      S_IDLE:
        if (qcnt != '0) state_n = S_REQ;
      S_REQ:
        if (bus.cntry == 2'd2) begin
          state_n = S_SERVE;
          timer_n = '0;
        end
      S_SERVE: begin
        timer_n = timer + 1'b1;
        // Drained queue wins over a coincident expiry: no timeout pulse.
        if (qcnt == '0)
          state_n = S_RELEASE;
        else if (timer == TW'(MAX_GREEN - 1)) begin
          state_n = S_RELEASE;
          to_n    = 1'b1;
        end
      end
      S_RELEASE:
        // Wait for the controller to finish its cycle before re-requesting.
        if (light_red) state_n = (qcnt != '0) ? S_REQ : S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
    // X registered alongside the state so it is a clean Moore output.
    x_n = (state_n == S_REQ) || (state_n == S_SERVE);
  end

  assign bus.X         = x_q;
  assign bus.queue_cnt = qcnt;
  assign bus.overflow  = ovf;
  assign bus.timeout   = to_q;

endmodule

// File: tb/tb_cntry_vehicle_detector.sv
// Scoreboard bench for cntry_vehicle_detector: stimulus pushes expected
// output snapshots tagged with a cycle number; a negedge monitor pops and
// compares them independently of the stimulus thread.
module tb_cntry_vehicle_detector;

  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  cntry_vehicle_detector_if #(.CNT_W(4)) bus ();

  cntry_vehicle_detector #(
    .DEBOUNCE (3),
    .CNT_W    (4),
    .MAX_GREEN(8)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  typedef struct {
    int         cyc;
    string      nm;
    logic       x;
    logic [3:0] q;
    logic       ov;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic ov_e  = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: compare every expectation whose cycle has come.
  always @(negedge clock) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_cmp++;
      if (bus.X !== e.x || bus.queue_cnt !== e.q ||
          bus.overflow !== e.ov || bus.timeout !== e.to) begin
        n_bad++;
        $display("FAIL %s @cyc %0d: got X=%b q=%0d ov=%b to=%b, want X=%b q=%0d ov=%b to=%b",
                 e.nm, cyc, bus.X, bus.queue_cnt, bus.overflow, bus.timeout,
                 e.x, e.q, e.ov, e.to);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic x, input int q,
                     input logic ov, input logic to);
    exp_t e;
    e.cyc = cyc;
    e.nm  = nm;
    e.x   = x;
    e.q   = 4'(q);
    e.ov  = ov;
    e.to  = to;
    sb.push_back(e);
  endtask

  // Clean 4-cycle sensor pulse, 10 cycles total. The rising event is
  // applied to the queue at the 6th edge, so check just before and after.
  task automatic pulse(input logic a, input logic d, input string nm,
                       input logic x, input int qb, input int qa,
                       input logic ova);
    bus.arrive_raw = a;
    bus.depart_raw = d;
    tick(4);
    bus.arrive_raw = 1'b0;
    bus.depart_raw = 1'b0;
    tick(1);
    chk({nm, "_pre"}, x, qb, ov_e, 1'b0);
    ov_e = ova;
    tick(1);
    chk({nm, "_post"}, x, qa, ov_e, 1'b0);
    tick(4);
  endtask

  initial begin
    clear          = 1'b0;
    bus.arrive_raw = 1'b0;
    bus.depart_raw = 1'b0;
    bus.cntry      = 2'd0;
    tick(2);
    chk("reset", 1'b0, 0, 1'b0, 1'b0);
    clear = 1'b1;

    // Glitch: s2 high for only 2 samples, must be rejected.
    bus.arrive_raw = 1'b1;
    tick(2);
    bus.arrive_raw = 1'b0;
    tick(8);
    chk("glitch", 1'b0, 0, 1'b0, 1'b0);

    // Basic request latency.
    bus.arrive_raw = 1'b1;
    tick(5);
    chk("basic_e5", 1'b0, 0, 1'b0, 1'b0);
    tick(1);
    chk("basic_e6", 1'b0, 1, 1'b0, 1'b0);
    tick(1);
    chk("basic_e7", 1'b1, 1, 1'b0, 1'b0);
    tick(3);
    bus.arrive_raw = 1'b0;
    tick(8);
    chk("basic_hold", 1'b1, 1, 1'b0, 1'b0);

    // Serve and drain.
    pulse(1'b1, 1'b0, "arr2", 1'b1, 1, 2, 1'b0);
    bus.depart_raw = 1'b1;
    tick(3);
    bus.depart_raw = 1'b0;
    tick(2);
    chk("drain_e5", 1'b1, 2, 1'b0, 1'b0);
    bus.cntry = 2'd2;
    tick(1);
    chk("drain_e6", 1'b1, 1, 1'b0, 1'b0);
    bus.depart_raw = 1'b1;
    tick(3);
    bus.depart_raw = 1'b0;
    tick(2);
    chk("drain_e11", 1'b1, 1, 1'b0, 1'b0);
    tick(1);
    chk("drain_e12", 1'b1, 0, 1'b0, 1'b0);
    tick(1);
    chk("drain_release", 1'b0, 0, 1'b0, 1'b0);
    tick(2);
    chk("release_hold", 1'b0, 0, 1'b0, 1'b0);
    bus.cntry = 2'd0;
    tick(1);
    chk("drain_idle", 1'b0, 0, 1'b0, 1'b0);

    // Max-green timeout.
    pulse(1'b1, 1'b0, "arr_t1", 1'b0, 0, 1, 1'b0);
    pulse(1'b1, 1'b0, "arr_t2", 1'b1, 1, 2, 1'b0);
    pulse(1'b1, 1'b0, "arr_t3", 1'b1, 2, 3, 1'b0);
    bus.cntry = 2'd2;
    tick(1);
    chk("serve_enter", 1'b1, 3, 1'b0, 1'b0);
    tick(7);
    chk("serve_last", 1'b1, 3, 1'b0, 1'b0);
    tick(1);
    chk("timeout", 1'b0, 3, 1'b0, 1'b1);
    tick(1);
    chk("timeout_end", 1'b0, 3, 1'b0, 1'b0);
    bus.cntry = 2'd0;
    tick(1);
    chk("rereq", 1'b1, 3, 1'b0, 1'b0);

    // Saturation and sticky overflow.
    for (int k = 3; k < 15; k++)
      pulse(1'b1, 1'b0, "sat", 1'b1, k, k + 1, 1'b0);
    pulse(1'b1, 1'b0, "sat_ovf", 1'b1, 15, 15, 1'b1);
    pulse(1'b1, 1'b0, "sat_hold", 1'b1, 15, 15, 1'b1);

    // Departures: green alone, coincident, red ignored, yellow counts.
    bus.cntry = 2'd2;
    pulse(1'b0, 1'b1, "dep_green", 1'b1, 15, 14, 1'b1);
    pulse(1'b1, 1'b1, "coinc", 1'b0, 14, 14, 1'b1);
    bus.cntry = 2'd0;
    tick(1);
    chk("rel_to_req", 1'b1, 14, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, "dep_red", 1'b1, 14, 14, 1'b1);
    bus.cntry = 2'd1;
    pulse(1'b0, 1'b1, "dep_yellow", 1'b1, 14, 13, 1'b1);

    // Reset while serving.
    bus.cntry = 2'd2;
    tick(3);
    chk("pre_reset", 1'b1, 13, 1'b1, 1'b0);
    clear = 1'b0;
    tick(1);
    clear = 1'b1;
    ov_e  = 1'b0;
    chk("mid_reset", 1'b0, 0, 1'b0, 1'b0);
    tick(2);
    chk("post_reset", 1'b0, 0, 1'b0, 1'b0);

    // Departure on an empty queue must not underflow.
    pulse(1'b0, 1'b1, "dep_empty", 1'b0, 0, 0, 1'b0);

    tick(2);
    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clock);
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_scoreboard: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
